// File: rtl/pe_stw_bisr.sv
// Output-stationary systolic PE with a table-driven multiply-add self-test
// sequencer and a sticky repair bypass. One multiplier/adder pair serves both
// normal accumulation and self-test vector execution.
module pe_stw_bisr #(
  parameter  int WORD_SIZE      = 16,
  parameter  int NUM_VECTORS    = 4,
  parameter  int FAIL_THRESHOLD = 1,
  localparam int IW             = (NUM_VECTORS > 1) ? $clog2(NUM_VECTORS) : 1,
  localparam int CW             = $clog2(NUM_VECTORS + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WORD_SIZE-1:0] left_in,
  input  logic [WORD_SIZE-1:0] top_in,
  input  logic                 mac_en,
  input  logic                 acc_clr,
  input  logic                 out_sel,
  output logic [WORD_SIZE-1:0] right_out,
  output logic [WORD_SIZE-1:0] bottom_out,
  input  logic [1:0]           fault_inject,
  input  logic                 stw_load_en,
  input  logic [IW-1:0]        stw_load_idx,
  input  logic [WORD_SIZE-1:0] stw_op1,
  input  logic [WORD_SIZE-1:0] stw_op2,
  input  logic [WORD_SIZE-1:0] stw_add,
  input  logic [WORD_SIZE-1:0] stw_expected,
  input  logic                 stw_start,
  input  logic                 stw_bypass_clr,
  output logic                 stw_busy,
  output logic                 stw_done,
  output logic                 stw_pass,
  output logic [CW-1:0]        stw_fail_count,
  output logic                 bypass
);

  localparam int DEPTH = 1 << IW;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_EXEC  = 2'd1,
    ST_CHECK = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Product corruption used to emulate a defective multiplier.
  function automatic logic [WORD_SIZE-1:0] apply_fault(
    input logic [WORD_SIZE-1:0] p,
    input logic [1:0]           f
  );
    logic [WORD_SIZE-1:0] r;
    case (f)
      2'b00:   r = p;
      2'b01:   r = {p[WORD_SIZE-1:1], 1'b0};
      2'b10:   r = {p[WORD_SIZE-1:1], 1'b1};
      2'b11:   r = {~p[WORD_SIZE-1], p[WORD_SIZE-2:0]};
      default: r = p;
    endcase
    return r;
  endfunction

  state_t               state_r, state_nxt_s;
  logic [WORD_SIZE-1:0] op1_r [DEPTH];
  logic [WORD_SIZE-1:0] op2_r [DEPTH];
  logic [WORD_SIZE-1:0] add_r [DEPTH];
  logic [WORD_SIZE-1:0] exp_r [DEPTH];
  logic [IW-1:0]        vec_idx_r;
  logic [CW-1:0]        fail_cnt_r;
  logic                 pass_r;
  logic                 bypass_r;
  logic [WORD_SIZE-1:0] acc_r;
  logic [WORD_SIZE-1:0] left_r;
  logic [WORD_SIZE-1:0] top_r;
  logic [WORD_SIZE-1:0] res_r;

  logic [WORD_SIZE-1:0] mul_a_s, mul_b_s, addend_s;
  logic [WORD_SIZE-1:0] mul_raw_s, prod_s, sum_s;
  logic                 idle_s, start_acc_s, last_vec_s, mismatch_s;
  logic [CW-1:0]        fail_next_s;
  logic [DEPTH-1:0]     idx_ok_s;

  // Table slots beyond NUM_VECTORS exist only to keep indexing in range.
  for (genvar j = 0; j < DEPTH; j++) begin : g_idx_ok
    assign idx_ok_s[j] = (j < NUM_VECTORS) ? 1'b1 : 1'b0;
  end

  assign idle_s      = (state_r == ST_IDLE);
  assign start_acc_s = idle_s & stw_start;
  assign last_vec_s  = (vec_idx_r == IW'(NUM_VECTORS - 1));
  assign mismatch_s  = (res_r != exp_r[vec_idx_r]);
  assign fail_next_s = fail_cnt_r + CW'(mismatch_s);

  // Shared datapath operand selection: table vector in EXEC, systolic operands otherwise.
  always_comb begin
    mul_a_s  = left_in;
    mul_b_s  = top_in;
    addend_s = acc_r;
    if (state_r == ST_EXEC) begin
      mul_a_s  = op1_r[vec_idx_r];
      mul_b_s  = op2_r[vec_idx_r];
      addend_s = add_r[vec_idx_r];
    end else if (acc_clr) begin
      addend_s = {WORD_SIZE{1'b0}};
    end else begin
      addend_s = acc_r;
    end
  end

  assign mul_raw_s = mul_a_s * mul_b_s;
  assign prod_s    = apply_fault(mul_raw_s, fault_inject);
  assign sum_s     = addend_s + prod_s;

  // Self-test sequencer next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (stw_start) state_nxt_s = ST_EXEC;
        else           state_nxt_s = ST_IDLE;
      end
      ST_EXEC:  state_nxt_s = ST_CHECK;
      ST_CHECK: begin
        if (last_vec_s) state_nxt_s = ST_DONE;
        else            state_nxt_s = ST_EXEC;
      end
      ST_DONE:  state_nxt_s = ST_IDLE;
      default:  state_nxt_s = ST_IDLE;
    endcase
  end

  // Sequencer state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_r <= ST_IDLE;
    else     state_r <= state_nxt_s;
  end

  // Vector index, failure count and pass flag bookkeeping across a run.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vec_idx_r  <= {IW{1'b0}};
      fail_cnt_r <= {CW{1'b0}};
      pass_r     <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start_acc_s) begin
            vec_idx_r  <= {IW{1'b0}};
            fail_cnt_r <= {CW{1'b0}};
            pass_r     <= 1'b0;
          end
        end
        ST_CHECK: begin
          fail_cnt_r <= fail_next_s;
          if (last_vec_s) pass_r <= (fail_next_s == {CW{1'b0}});
          else            vec_idx_r <= vec_idx_r + IW'(1);
        end
        default: begin
          vec_idx_r <= vec_idx_r;
        end
      endcase
    end
  end

  // Sticky bypass: only an idle clear lowers it, a failing run raises it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bypass_r <= 1'b0;
    end else if (idle_s && stw_bypass_clr) begin
      bypass_r <= 1'b0;
    end else if ((state_r == ST_CHECK) && last_vec_s &&
                 (fail_next_s >= CW'(FAIL_THRESHOLD))) begin
      bypass_r <= 1'b1;
    end
  end

  // Test-vector table, writable only while idle and in range.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        op1_r[i] <= {WORD_SIZE{1'b0}};
        op2_r[i] <= {WORD_SIZE{1'b0}};
        add_r[i] <= {WORD_SIZE{1'b0}};
        exp_r[i] <= {WORD_SIZE{1'b0}};
      end
    end else if (idle_s && stw_load_en && idx_ok_s[stw_load_idx]) begin
      op1_r[stw_load_idx] <= stw_op1;
      op2_r[stw_load_idx] <= stw_op2;
      add_r[stw_load_idx] <= stw_add;
      exp_r[stw_load_idx] <= stw_expected;
    end
  end

  // Systolic operand pipeline keeps shifting regardless of test or bypass.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      left_r <= {WORD_SIZE{1'b0}};
      top_r  <= {WORD_SIZE{1'b0}};
    end else begin
      left_r <= left_in;
      top_r  <= top_in;
    end
  end

  // Accumulator: frozen while testing or bypassed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_r <= {WORD_SIZE{1'b0}};
    end else if (idle_s && !bypass_r && (mac_en || acc_clr)) begin
      acc_r <= mac_en ? sum_s : {WORD_SIZE{1'b0}};
    end
  end

  // Captures the executed vector result for comparison in CHECK.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    res_r <= {WORD_SIZE{1'b0}};
    else if (state_r == ST_EXEC) res_r <= sum_s;
  end

  // Output steering; bypass forwards the neighbours' operands with no latency.
  always_comb begin
    right_out  = left_r;
    bottom_out = top_r;
    if (bypass_r) begin
      right_out  = left_in;
      bottom_out = top_in;
    end else if (out_sel) begin
      bottom_out = acc_r;
    end else begin
      bottom_out = top_r;
    end
  end

  assign stw_busy       = ~idle_s;
  assign stw_done       = (state_r == ST_DONE);
  assign stw_pass       = pass_r;
  assign stw_fail_count = fail_cnt_r;
  assign bypass         = bypass_r;

endmodule

// File: tb/tb_pe_stw_bisr.sv
// Directed bench for pe_stw_bisr with a cycle-level behavioural model that
// derives run timing from the acceptance cycle and vector results arithmetically.
module tb_pe_stw_bisr;
  localparam int W   = 16;
  localparam int NV  = 4;
  localparam int THR = 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [W-1:0]  left_in, top_in;
  logic          mac_en, acc_clr, out_sel;
  logic [W-1:0]  right_out, bottom_out;
  logic [1:0]    fault_inject;
  logic          stw_load_en;
  logic [1:0]    stw_load_idx;
  logic [W-1:0]  stw_op1, stw_op2, stw_add, stw_expected;
  logic          stw_start, stw_bypass_clr;
  logic          stw_busy, stw_done, stw_pass, bypass;
  logic [2:0]    stw_fail_count;

  pe_stw_bisr #(.WORD_SIZE(W), .NUM_VECTORS(NV), .FAIL_THRESHOLD(THR)) dut (
    .clk(clk), .rst(rst), .left_in(left_in), .top_in(top_in),
    .mac_en(mac_en), .acc_clr(acc_clr), .out_sel(out_sel),
    .right_out(right_out), .bottom_out(bottom_out),
    .fault_inject(fault_inject), .stw_load_en(stw_load_en),
    .stw_load_idx(stw_load_idx), .stw_op1(stw_op1), .stw_op2(stw_op2),
    .stw_add(stw_add), .stw_expected(stw_expected), .stw_start(stw_start),
    .stw_bypass_clr(stw_bypass_clr), .stw_busy(stw_busy), .stw_done(stw_done),
    .stw_pass(stw_pass), .stw_fail_count(stw_fail_count), .bypass(bypass)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Model state
  int           cyc = 0;
  logic [W-1:0] t_op1 [NV], t_op2 [NV], t_add [NV], t_exp [NV];
  logic [W-1:0] m_left, m_top, m_acc;
  logic         m_byp, m_pass_hold, m_run;
  int           m_fail_hold, m_k, m_total;
  logic         m_flag [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] mprod(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic [1:0] f);
    int unsigned p;
    p = (32'(a) * 32'(b)) & 32'h0000FFFF;
    case (f)
      2'b01:   p = p - (p % 2);
      2'b10:   p = p | 32'd1;
      2'b11:   p = p ^ 32'h00008000;
      default: p = p;
    endcase
    return p[W-1:0];
  endfunction

  function automatic int phase();
    return cyc - m_k;
  endfunction

  function automatic logic exp_byp();
    if (m_run && phase() == 8 && m_total >= THR) return 1'b1;
    return m_byp;
  endfunction

  function automatic int exp_fail();
    int n = 0;
    if (!m_run) return m_fail_hold;
    for (int i = 0; i < NV; i++)
      if (m_flag[i] && (2 * i + 2) <= phase()) n++;
    return n;
  endfunction

  function automatic logic exp_pass();
    if (!m_run) return m_pass_hold;
    return (phase() == 8) && (m_total == 0);
  endfunction

  task automatic model_reset();
    m_left = '0; m_top = '0; m_acc = '0;
    m_byp = 1'b0; m_pass_hold = 1'b0; m_run = 1'b0;
    m_fail_hold = 0; m_k = 0; m_total = 0;
    for (int i = 0; i < NV; i++) begin
      t_op1[i] = '0; t_op2[i] = '0; t_add[i] = '0; t_exp[i] = '0; m_flag[i] = 1'b0;
    end
  endtask

  task automatic model_edge();
    logic [W-1:0] p;
    logic [W-1:0] r;
    p = mprod(left_in, top_in, fault_inject);
    if (!m_run && !exp_byp()) begin
      if (acc_clr && mac_en) m_acc = p;
      else if (acc_clr)      m_acc = '0;
      else if (mac_en)       m_acc = m_acc + p;
    end
    m_left = left_in;
    m_top  = top_in;
    if (m_run) begin
      if (phase() == 8) begin
        m_run       = 1'b0;
        m_fail_hold = m_total;
        m_pass_hold = (m_total == 0);
        if (m_total >= THR) m_byp = 1'b1;
      end
    end else begin
      if (stw_load_en) begin
        t_op1[stw_load_idx] = stw_op1; t_op2[stw_load_idx] = stw_op2;
        t_add[stw_load_idx] = stw_add; t_exp[stw_load_idx] = stw_expected;
      end
      if (stw_bypass_clr) m_byp = 1'b0;
      if (stw_start) begin
        m_run = 1'b1; m_k = cyc + 1; m_fail_hold = 0; m_pass_hold = 1'b0; m_total = 0;
        for (int i = 0; i < NV; i++) begin
          r = mprod(t_op1[i], t_op2[i], fault_inject) + t_add[i];
          m_flag[i] = (r != t_exp[i]);
          if (m_flag[i]) m_total++;
        end
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (rst) model_reset();
    else     model_edge();
    cyc++;
    #1;
  endtask

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    logic         b;
    logic [W-1:0] er, eb;
    b  = exp_byp();
    er = b ? left_in : m_left;
    eb = b ? top_in : (out_sel ? m_acc : m_top);
    chk("right_out", right_out, er);
    chk("bottom_out", bottom_out, eb);
    chk("stw_busy", stw_busy, m_run);
    chk("stw_done", stw_done, m_run && phase() == 8);
    chk("stw_pass", stw_pass, exp_pass());
    chk("stw_fail_count", stw_fail_count, exp_fail());
    chk("bypass", bypass, b);
  end

  task automatic load(input logic [1:0] idx, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [W-1:0] c, input logic [W-1:0] e);
    stw_load_en = 1'b1; stw_load_idx = idx;
    stw_op1 = a; stw_op2 = b; stw_add = c; stw_expected = e;
    step();
    stw_load_en = 1'b0;
  endtask

  task automatic load_clean();
    load(2'd0, 16'd2, 16'd3, 16'd1, 16'd7);
    load(2'd1, 16'hFFFF, 16'd2, 16'd0, 16'hFFFE);
    load(2'd2, 16'd10, 16'd10, 16'd5, 16'd105);
    load(2'd3, 16'd0, 16'd9, 16'd4, 16'd4);
  endtask

  // Accepts a start and advances to the DONE cycle.
  task automatic run_to_done();
    stw_start = 1'b1;
    step();
    stw_start = 1'b0;
    repeat (8) step();
  endtask

  initial begin
    rst = 1'b1;
    left_in = '0; top_in = '0; mac_en = 1'b0; acc_clr = 1'b0; out_sel = 1'b0;
    fault_inject = 2'b00; stw_load_en = 1'b0; stw_load_idx = 2'd0;
    stw_op1 = '0; stw_op2 = '0; stw_add = '0; stw_expected = '0;
    stw_start = 1'b0; stw_bypass_clr = 1'b0;
    model_reset();
    repeat (2) step();
    rst = 1'b0;
    #1;
    chk("reset_busy", stw_busy, 1'b0);
    chk("reset_bypass", bypass, 1'b0);
    chk("reset_bottom", bottom_out, 16'd0);

    // MAC
    out_sel = 1'b1; acc_clr = 1'b1;
    step();
    acc_clr = 1'b0; mac_en = 1'b1; left_in = 16'd3; top_in = 16'd4;
    step();
    chk("mac_first", bottom_out, 16'd12);
    chk("right_delay1", right_out, 16'd3);
    left_in = 16'd5; top_in = 16'd6;
    step();
    chk("mac_second", bottom_out, 16'd42);
    chk("right_delay2", right_out, 16'd5);
    mac_en = 1'b0; left_in = '0; top_in = '0; out_sel = 1'b0;

    // Clean run
    load_clean();
    run_to_done();
    chk("clean_done", stw_done, 1'b1);
    chk("clean_pass", stw_pass, 1'b1);
    chk("clean_fail_count", stw_fail_count, 3'd0);
    chk("clean_bypass", bypass, 1'b0);
    step();
    chk("clean_busy_drop", stw_busy, 1'b0);

    // Injected fault: every result gets bit0 forced high
    fault_inject = 2'b10;
    run_to_done();
    chk("fault_fail_count", stw_fail_count, 3'd4);
    chk("fault_pass", stw_pass, 1'b0);
    chk("fault_bypass", bypass, 1'b1);
    step();
    left_in = 16'h1234; top_in = 16'hABCD; mac_en = 1'b1; out_sel = 1'b1;
    #1;
    chk("bypass_right", right_out, 16'h1234);
    chk("bypass_bottom", bottom_out, 16'hABCD);
    step();
    mac_en = 1'b0; left_in = '0; top_in = '0;

    // Stuck-at-0 on bit0 leaves even products intact
    fault_inject = 2'b01;
    run_to_done();
    chk("sa0_pass", stw_pass, 1'b1);
    chk("sa0_fail_count", stw_fail_count, 3'd0);
    chk("sa0_bypass_sticky", bypass, 1'b1);
    step();

    // Bypass clear coinciding with start
    fault_inject = 2'b00;
    stw_start = 1'b1; stw_bypass_clr = 1'b1;
    step();
    stw_start = 1'b0; stw_bypass_clr = 1'b0;
    chk("clr_bypass_now", bypass, 1'b0);
    chk("clr_busy", stw_busy, 1'b1);
    repeat (8) step();
    chk("clr_pass", stw_pass, 1'b1);
    step();
    out_sel = 1'b1;
    #1;
    chk("acc_held", bottom_out, 16'd42);
    out_sel = 1'b0;

    // Reset during EXEC of vector 2
    stw_start = 1'b1;
    step();
    stw_start = 1'b0;
    repeat (4) step();
    rst = 1'b1;
    model_reset();
    #1;
    chk("rst_busy", stw_busy, 1'b0);
    chk("rst_done", stw_done, 1'b0);
    chk("rst_right", right_out, 16'd0);
    chk("rst_bottom", bottom_out, 16'd0);
    step();
    rst = 1'b0;
    step();
    run_to_done();
    chk("zero_table_pass", stw_pass, 1'b1);
    step();

    // Ignored requests while busy, and a start during DONE
    load_clean();
    stw_start = 1'b1;
    step();
    stw_start = 1'b0;
    repeat (2) step();
    stw_start = 1'b1; stw_bypass_clr = 1'b1;
    stw_load_en = 1'b1; stw_load_idx = 2'd1; stw_expected = 16'd0;
    stw_op1 = 16'd0; stw_op2 = 16'd0; stw_add = 16'd0;
    step();
    stw_start = 1'b0; stw_bypass_clr = 1'b0; stw_load_en = 1'b0;
    repeat (5) step();
    chk("ign_done", stw_done, 1'b1);
    chk("ign_pass", stw_pass, 1'b1);
    chk("ign_fail_count", stw_fail_count, 3'd0);
    stw_start = 1'b1;
    step();
    stw_start = 1'b0;
    chk("ign_busy_after", stw_busy, 1'b0);
    step();
    chk("ign_no_restart", stw_busy, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
